// File: rtl/axi_lite_arith_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_arith_slave
//
// AXI-Lite slave window holding two operand registers and exposing their sum
// and product as read-only result registers.
//
// Register map (byte offsets from BASE_ADDR):
//   +0  OP_A    RW
//   +4  OP_B    RW
//   +8  SUM     RO  (OP_A + OP_B, registered one cycle after an operand change)
//   +12 PRODUCT RO  (low DATA_WIDTH bits of OP_A * OP_B, shift-add, 1 bit/cycle)
// Any other offset answers SLVERR. Writes to +8/+12 answer SLVERR and change
// nothing.
//
// Handshake rule used on every channel: a transfer happens on the rising
// clock edge where valid and ready are both 1. A source holds valid and its
// payload stable until that edge. All ready/valid outputs here are registered.
//
// Ports:
//   s0_axi_aclk / s0_axi_areset   clock, synchronous active-high reset
//   s0_axi_aw*                    write address channel
//   s0_axi_w*                     write data channel (wstrb MSB is ignored)
//   s0_axi_b*                     write response channel
//   s0_axi_ar*                    read address channel
//   s0_axi_r*                     read data channel
//   rd_state_dbg_o                current read FSM state (observation only)
// ---------------------------------------------------------------------------
module axi_lite_arith_slave #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          RESP_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  output logic [1:0]              rd_state_dbg_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(DATA_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OFF_A = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_B = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OFF_S = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] OFF_P = ADDR_WIDTH'(12);

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  // The top strobe bit has no byte lane behind it.
  logic unused_wstrb_msb;
  assign unused_wstrb_msb = s0_axi_wstrb[NBYTES];

  // -------------------------------------------------------------------------
  // Write path state
  // -------------------------------------------------------------------------
  logic                  aw_held_q, w_held_q;
  logic                  aw_held_d, w_held_d;
  logic                  awready_q, wready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NBYTES-1:0]     wstrb_q;
  logic                  bvalid_q;
  logic [RESP_WIDTH-1:0] bresp_q;

  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, op_a_d, op_b_d;
  logic [DATA_WIDTH-1:0] sum_q, product_q;

  logic                  aw_fire, w_fire, b_fire, commit, wr_ok, start_mul;
  logic [ADDR_WIDTH-1:0] wr_off;

  assign aw_fire = s0_axi_awvalid & awready_q;
  assign w_fire  = s0_axi_wvalid & wready_q;
  assign b_fire  = bvalid_q & s0_axi_bready;

  // Commit exactly once per transaction: bvalid_q stays high until the B
  // handshake, which is also what releases the held address/data.
  assign commit    = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_off    = awaddr_q - BASE;
  assign wr_ok     = (wr_off == OFF_A) || (wr_off == OFF_B);
  assign start_mul = commit & wr_ok;

  // Ready can never coincide with a held entry, so capture and release are
  // mutually exclusive per channel.
  assign aw_held_d = b_fire ? 1'b0 : (aw_fire ? 1'b1 : aw_held_q);
  assign w_held_d  = b_fire ? 1'b0 : (w_fire  ? 1'b1 : w_held_q);

  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (start_mul) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wstrb_q[i]) begin
          if (wr_off == OFF_A) op_a_d[8*i +: 8] = wdata_q[8*i +: 8];
          else                 op_b_d[8*i +: 8] = wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sum_q     <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= ~aw_held_d;
      wready_q  <= ~w_held_d;
      if (aw_fire) awaddr_q <= s0_axi_awaddr;
      if (w_fire) begin
        wdata_q <= s0_axi_wdata;
        wstrb_q <= s0_axi_wstrb[NBYTES-1:0];
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_fire) begin
        bvalid_q <= 1'b0;
      end
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sum_q  <= op_a_q + op_b_q;
    end
  end

  // -------------------------------------------------------------------------
  // Shift-add multiplier: one multiplier bit per cycle, LSB first.
  // -------------------------------------------------------------------------
  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (start_mul) begin
      // A new operand write always restarts from bit 0 with fresh operands.
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= op_a_d;
      mplier_q <= op_b_d;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
        product_q <= acc_next;
        busy_q    <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  rd_state_e             rd_state_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [RESP_WIDTH-1:0] rresp_q;

  logic                  ar_fire;
  logic [ADDR_WIDTH-1:0] ar_off;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [RESP_WIDTH-1:0] rd_resp_c;

  assign ar_fire = s0_axi_arvalid & arready_q;
  assign ar_off  = s0_axi_araddr - BASE;

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (ar_off)
      OFF_A:   rd_data_c = op_a_q;
      OFF_B:   rd_data_c = op_b_q;
      OFF_S:   rd_data_c = sum_q;
      OFF_P:   rd_data_c = product_q;
      default: rd_resp_c = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            arready_q <= 1'b0;
            // A product read must not see a value that is about to be
            // replaced, including by a multiply starting on this very edge.
            if ((ar_off == OFF_P) && (busy_q || start_mul)) begin
              rd_state_q <= R_WAIT;
            end else begin
              rd_state_q <= R_RESP;
              rvalid_q   <= 1'b1;
              rdata_q    <= rd_data_c;
              rresp_q    <= rd_resp_c;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (!busy_q) begin
            rd_state_q <= R_RESP;
            rvalid_q   <= 1'b1;
            rdata_q    <= product_q;
            rresp_q    <= RESP_OKAY;
          end
        end
        R_RESP: begin
          if (s0_axi_rready) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_bvalid  = bvalid_q;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_arready = arready_q;
  assign s0_axi_rvalid  = rvalid_q;
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;
  assign rd_state_dbg_o = rd_state_q;

endmodule

// File: tb/tb_axi_lite_arith_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_arith_slave
//
// Directed scenarios followed by randomized single-outstanding reads and
// writes. A register-level model (plain arithmetic on two operands) supplies
// every expected read value and response code.
// ---------------------------------------------------------------------------
module tb_axi_lite_arith_slave;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int SW = DW / 8 + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid, wready;
  logic [RW-1:0] bresp;
  logic          bvalid, bready;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [RW-1:0] rresp;
  logic          rvalid, rready;
  logic [1:0]    rd_state_dbg;

  axi_lite_arith_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESP_WIDTH (RW),
    .BASE_ADDR  (0)
  ) dut (
    .s0_axi_aclk    (clk),
    .s0_axi_areset  (areset),
    .s0_axi_awaddr  (awaddr),
    .s0_axi_awvalid (awvalid),
    .s0_axi_awready (awready),
    .s0_axi_wdata   (wdata),
    .s0_axi_wstrb   (wstrb),
    .s0_axi_wvalid  (wvalid),
    .s0_axi_wready  (wready),
    .s0_axi_bresp   (bresp),
    .s0_axi_bvalid  (bvalid),
    .s0_axi_bready  (bready),
    .s0_axi_araddr  (araddr),
    .s0_axi_arvalid (arvalid),
    .s0_axi_arready (arready),
    .s0_axi_rdata   (rdata),
    .s0_axi_rresp   (rresp),
    .s0_axi_rvalid  (rvalid),
    .s0_axi_rready  (rready),
    .rd_state_dbg_o (rd_state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] m_a, m_b;
  bit            mul_pending;
  int            commit_cyc;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model
  task automatic model_read(input logic [AW-1:0] off, output logic [DW-1:0] d, output logic [RW-1:0] r);
    r = 0;
    case (off)
      8'd0:    d = m_a;
      8'd4:    d = m_b;
      8'd8:    d = m_a + m_b;
      8'd12:   d = m_a * m_b;
      default: begin d = 0; r = 2; end
    endcase
  endtask

  task automatic model_write(input logic [AW-1:0] off, input logic [DW-1:0] data, input logic [SW-1:0] strb);
    for (int i = 0; i < DW / 8; i++) begin
      if (strb[i]) begin
        if (off == 8'd0) m_a[8*i +: 8] = data[8*i +: 8];
        else             m_b[8*i +: 8] = data[8*i +: 8];
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_awready"}, awready, 0);
    check_eq({tag, "_wready"},  wready,  0);
    check_eq({tag, "_arready"}, arready, 0);
    check_eq({tag, "_bvalid"},  bvalid,  0);
    check_eq({tag, "_rvalid"},  rvalid,  0);
    check_eq({tag, "_bresp"},   bresp,   0);
    check_eq({tag, "_rresp"},   rresp,   0);
    check_eq({tag, "_rdata"},   rdata,   0);
  endtask

  // driver tasks (all entered and left at a negedge)
  task automatic apply_reset(input int n);
    areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    repeat (n) @(negedge clk);
    check_idle_zero("rst");
    areset = 0;
    m_a = 0; m_b = 0; mul_pending = 0;
    @(negedge clk);
    check_eq("post_rst_awready", awready, 1);
    check_eq("post_rst_wready",  wready,  1);
    check_eq("post_rst_arready", arready, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int wdelay, input int bdelay);
    bit aw_done, w_done, ok;
    int t, c;
    logic [RW-1:0] r0;
    aw_done = 0; w_done = 0; t = 0;
    awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = (wdelay == 0);
    while (!(aw_done && w_done) && t < 50) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      @(negedge clk); t++;
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0; else if (t >= wdelay) wvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    check_eq("wr_accept", aw_done && w_done, 1);
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    check_eq("wr_bvalid", bvalid, 1);
    c  = cyc;
    ok = (addr == 8'd0) || (addr == 8'd4);
    check_eq("wr_bresp", bresp, ok ? 0 : 2);
    r0 = bresp;
    repeat (bdelay) begin
      @(negedge clk);
      check_eq("b_hold_valid", bvalid, 1);
      check_eq("b_hold_resp",  bresp,  r0);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check_eq("b_done_valid",   bvalid,  0);
    check_eq("aw_rdy_after_b", awready, 1);
    check_eq("w_rdy_after_b",  wready,  1);
    if (ok) begin
      model_write(addr, data, strb);
      mul_pending = 1;
      commit_cyc  = c;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int rdelay);
    logic [DW-1:0] ed, d0;
    logic [RW-1:0] er;
    int t, h, lat;
    araddr = addr; arvalid = 1; t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    check_eq("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 0; h = cyc; lat = 1;
    while (!rvalid && lat < 200) begin @(negedge clk); lat++; end
    check_eq("rd_rvalid", rvalid, 1);
    model_read(addr, ed, er);
    check_eq("rd_data", rdata, ed);
    check_eq("rd_resp", rresp, er);
    if (addr == 8'd12 && mul_pending) begin
      if (h <= commit_cyc + 30)      check_eq("rd_stalled", lat > 1, 1);
      else if (h > commit_cyc + 34)  check_eq("rd_lat", lat, 1);
    end else begin
      check_eq("rd_lat", lat, 1);
    end
    d0 = rdata;
    repeat (rdelay) begin
      @(negedge clk);
      check_eq("r_hold_valid", rvalid, 1);
      check_eq("r_hold_data",  rdata,  d0);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check_eq("r_done_valid",    rvalid,  0);
    check_eq("ar_rdy_after_r",  arready, 1);
  endtask

  localparam logic [SW-1:0] STRB_ALL = '1;

  initial begin
    int t;
    logic [AW-1:0] a;
    areset = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arvalid = 0; rready = 0;
    m_a = 0; m_b = 0; mul_pending = 0; commit_cyc = 0;
    @(negedge clk);
    apply_reset(3);

    // basic sum / product
    do_write(8'd0, 32'd7, STRB_ALL, 0, 0);
    do_write(8'd4, 32'd6, STRB_ALL, 2, 0);
    do_read(8'd8, 0);
    repeat (DW) @(negedge clk);
    do_read(8'd12, 0);

    // product read while the multiplier is running must stall
    do_write(8'd4, 32'd5, STRB_ALL, 0, 0);
    do_read(8'd12, 0);

    // byte strobes, and the ignored strobe MSB
    do_write(8'd0, 32'h12345678, STRB_ALL, 0, 0);
    do_write(8'd0, 32'h000000FF, 5'b00001, 0, 0);
    do_read(8'd0, 0);
    do_write(8'd0, 32'hAAAAAAAA, 5'b10000, 1, 0);
    do_read(8'd0, 0);

    // error responses
    do_write(8'd8, 32'hDEADBEEF, STRB_ALL, 0, 0);
    do_write(8'd12, 32'hDEADBEEF, STRB_ALL, 0, 0);
    do_read(8'h40, 0);
    do_read(8'd0, 0);
    do_read(8'd4, 0);
    do_read(8'd12, 0);

    // wraparound with back-pressure on B and R
    do_write(8'd0, 32'hFFFFFFFF, STRB_ALL, 0, 5);
    do_write(8'd4, 32'd2, STRB_ALL, 0, 5);
    do_read(8'd8, 5);
    do_read(8'd12, 5);

    // reset mid-multiply with AW captured and W still pending
    do_write(8'd0, 32'd11, STRB_ALL, 0, 0);
    awaddr = 8'd4; awvalid = 1; t = 0;
    while (!awready && t < 20) begin @(negedge clk); t++; end
    check_eq("aw_pre_rst", awready, 1);
    @(negedge clk);
    awvalid = 0;
    apply_reset(2);
    do_read(8'd0, 0);
    do_read(8'd4, 0);
    do_read(8'd8, 0);
    do_read(8'd12, 0);
    do_write(8'd0, 32'd9, STRB_ALL, 0, 0);
    do_read(8'd0, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: a = 8'd0;
        1: a = 8'd4;
        2: a = 8'd8;
        3: a = 8'd12;
        default: a = AW'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, SW'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
